riscv_run_ctrl: RTL and testbench
=================================

# riscv_run_ctrl

Parametrised run controller that sits between the simulation/board top and one or more `riscv_pipeline` instances. It sequences core reset for a programmable number of cycles and gates execution with the `ligar` run request. It counts cycles and retired instructions, detects program completion (all cores halted) or a cycle-budget timeout, and exposes the run status. It generalises the fixed reset/run timing previously hard-coded in benches into synthesizable, N-core RTL.

## Interface
- `NUM_CORES`, 1, number of pipeline instances controlled (1..8)
- `RESET_CYCLES`, 2, cycles `core_reset` is held high per start (>=1)
- `MAX_CYCLES`, 1000, RUN-cycle budget before timeout; 0 disables timeout
- `CNT_W`, 32, width of both counters

- `clock`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-low controller reset
- `ligar`  in  1  run request (level): 1 = start/continue, 0 = pause/stop
- `core_halt`  in  NUM_CORES  per-core halt pulse or level (ebreak/ecall retired)
- `core_retire`  in  NUM_CORES  per-core instruction-retired strobe
- `core_reset`  out  1  active-high reset to all pipelines
- `core_enable`  out  1  clock-enable to all pipelines
- `cycle_count`  out  CNT_W  RUN cycles since last start
- `retire_count`  out  CNT_W  total instructions retired since last start
- `state`  out  3  current FSM state encoding
- `done`  out  1  run finished (halt or timeout)
- `timeout`  out  1  run ended by budget exhaustion

## Operation
- All outputs registered. Reset (`reset`=0 at edge): state=IDLE, `core_reset`=1, `core_enable`=0, counters=0, halted mask=0, `done`=0, `timeout`=0.
- IDLE: `core_reset`=1, `core_enable`=0. `ligar`=1 -> RESET; on entry clear counters, halted mask, `done`, `timeout`; load reset counter with RESET_CYCLES-1.
- RESET: `core_reset`=1 for exactly RESET_CYCLES cycles, then -> RUN. `ligar` ignored in RESET.
- RUN: `core_reset`=0, `core_enable`=1. Each cycle `cycle_count`+=1 and `retire_count`+=popcount(`core_retire`). Halted mask |= `core_halt`.
  - Halted mask (including this cycle's `core_halt`) all ones -> DONE, `done`=1.
  - Otherwise, `cycle_count` reaching MAX_CYCLES (MAX_CYCLES!=0) -> DONE, `done`=1, `timeout`=1.
  - Otherwise, `ligar`=0 -> PAUSE.
- Halt and budget in the same cycle: halt wins, `timeout`=0. Halt and `ligar`=0 in the same cycle: DONE.
- PAUSE: `core_enable`=0, `core_reset`=0, counters and mask hold, inputs ignored. `ligar`=1 -> RUN.
- DONE: `core_enable`=0, `core_reset`=0; `done`/`timeout`/counters hold. `ligar`=0 -> IDLE (status held until next start).
- Counters saturate at all-ones, never wrap. `core_retire`/`core_halt` count only in RUN.
- `reset` low in any state, mid-run included, forces the reset values on the next edge.

## Timing
- `ligar` sampled high at edge k in IDLE: state=RESET after edge k; `core_reset` remains 1 through edge k+RESET_CYCLES; state=RUN and `core_enable`=1 after edge k+RESET_CYCLES.
- A retire strobe in a RUN cycle is visible on `retire_count` one cycle later.
- Halt seen at edge k: `core_enable`=0 and `done`=1 after edge k (1-cycle latency).
- Timeout: `done` rises after the edge at which `cycle_count` becomes MAX_CYCLES, so exactly MAX_CYCLES enabled cycles run.
- PAUSE/resume: each is a 1-cycle transition; no counts are lost or doubled.

## Structure
- Package `riscv_run_pkg`: state encodings IDLE=0, RESET=1, RUN=2, PAUSE=3, DONE=4; state width constant 3.
- Sub-module `riscv_popcount` (parametrised by NUM_CORES): combinational population count of `core_retire`, output width $clog2(NUM_CORES+1).
- Top: FSM, reset-length counter, two saturating counters, sticky halted mask.

## Test plan
- Reset, NUM_CORES=1, RESET_CYCLES=3, `ligar`=1 at cycle 5 -> `core_reset` high for exactly 3 cycles after the start edge; `core_enable` rises on the 4th; `cycle_count` increments from 0.
- RUN, `core_retire` strobed 10 times, `core_halt` pulse at RUN cycle 20 -> `done`=1, `timeout`=0, `retire_count`=10, `cycle_count`=20, `core_enable`=0 the next cycle.
- MAX_CYCLES=50, no halt -> `done`=1, `timeout`=1, `cycle_count`=50; halt on the 50th cycle instead -> `timeout`=0.
- NUM_CORES=4, halts on cores 0, 2, 1, 3 at separate cycles, all four retiring each cycle -> DONE only after core 3 halts; `retire_count` grows by 4 per cycle.
- `ligar`=0 for 7 cycles mid-RUN -> PAUSE; counters frozen; resume adds no extra count.
- `reset`=0 during RUN -> next cycle state=IDLE, counters 0, `core_reset`=1; CNT_W=4 with 20 cycles -> `cycle_count` saturates at 15.

Source files
------------

// File: rtl/riscv_run_pkg.sv
// rtl/riscv_run_pkg.sv - shared state encodings for the run controller
package riscv_run_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_RESET = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } run_state_t;

endpackage

// File: rtl/riscv_popcount.sv
// rtl/riscv_popcount.sv - combinational population count of a per-core strobe vector
module riscv_popcount #(
  parameter int NUM_CORES = 1,
  parameter int OUT_W     = $clog2(NUM_CORES + 1)
) (
  input  logic [NUM_CORES-1:0] bits,
  output logic [OUT_W-1:0]     count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      count = count + OUT_W'(bits[i]);
    end
  end

endmodule

// File: rtl/riscv_run_ctrl.sv
// rtl/riscv_run_ctrl.sv - core reset sequencing, run gating, cycle/retire counting and completion detect
module riscv_run_ctrl
  import riscv_run_pkg::*;
#(
  parameter int              NUM_CORES    = 1,
  parameter int              RESET_CYCLES = 2,
  parameter longint unsigned MAX_CYCLES   = 1000,
  parameter int              CNT_W        = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ligar,
  input  logic [NUM_CORES-1:0] core_halt,
  input  logic [NUM_CORES-1:0] core_retire,
  output logic                 core_reset,
  output logic                 core_enable,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [CNT_W-1:0]     retire_count,
  output logic [STATE_W-1:0]   state,
  output logic                 done,
  output logic                 timeout
);

  localparam int PC_W = $clog2(NUM_CORES + 1);
  localparam int RC_W = $clog2(RESET_CYCLES + 1);
  localparam logic [RC_W-1:0] RST_LOAD = RC_W'(RESET_CYCLES - 1);
  localparam bit TO_EN = (MAX_CYCLES != 0);

  run_state_t st, st_nxt;
  logic [RC_W-1:0]      rst_cnt, rst_cnt_nxt;
  logic [CNT_W-1:0]     cyc_nxt, ret_nxt, cyc_inc, ret_inc;
  logic [NUM_CORES-1:0] halted, halted_nxt;
  logic                 done_nxt, timeout_nxt;
  logic [PC_W-1:0]      retire_pop;
  logic [CNT_W:0]       ret_sum;

  riscv_popcount #(.NUM_CORES(NUM_CORES), .OUT_W(PC_W)) u_popcount (
    .bits  (core_retire),
    .count (retire_pop)
  );

  // Both counters saturate instead of wrapping.
  assign cyc_inc = (&cycle_count) ? cycle_count : cycle_count + 1'b1;
  assign ret_sum = {1'b0, retire_count} + (CNT_W+1)'(retire_pop);
  assign ret_inc = ret_sum[CNT_W] ? '1 : ret_sum[CNT_W-1:0];
  assign state   = st;

  always_comb begin
    st_nxt      = st;
    rst_cnt_nxt = rst_cnt;
    cyc_nxt     = cycle_count;
    ret_nxt     = retire_count;
    halted_nxt  = halted;
    done_nxt    = done;
    timeout_nxt = timeout;
    case (st)
      S_IDLE: begin
        if (ligar) begin
          st_nxt      = S_RESET;
          rst_cnt_nxt = RST_LOAD;
          cyc_nxt     = '0;
          ret_nxt     = '0;
          halted_nxt  = '0;
          done_nxt    = 1'b0;
          timeout_nxt = 1'b0;
        end
      end
      S_RESET: begin
        if (rst_cnt == '0) st_nxt = S_RUN;
        else               rst_cnt_nxt = rst_cnt - 1'b1;
      end
      S_RUN: begin
        cyc_nxt    = cyc_inc;
        ret_nxt    = ret_inc;
        halted_nxt = halted | core_halt;
        // Completion by halt takes priority over both budget and pause.
        if (&halted_nxt) begin
          st_nxt   = S_DONE;
          done_nxt = 1'b1;
        end else if (TO_EN && (64'(cyc_inc) == MAX_CYCLES)) begin
          st_nxt      = S_DONE;
          done_nxt    = 1'b1;
          timeout_nxt = 1'b1;
        end else if (!ligar) begin
          st_nxt = S_PAUSE;
        end
      end
      S_PAUSE: if (ligar) st_nxt = S_RUN;
      S_DONE:  if (!ligar) st_nxt = S_IDLE;
      default: st_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      st           <= S_IDLE;
      rst_cnt      <= '0;
      cycle_count  <= '0;
      retire_count <= '0;
      halted       <= '0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      core_reset   <= 1'b1;
      core_enable  <= 1'b0;
    end else begin
      st           <= st_nxt;
      rst_cnt      <= rst_cnt_nxt;
      cycle_count  <= cyc_nxt;
      retire_count <= ret_nxt;
      halted       <= halted_nxt;
      done         <= done_nxt;
      timeout      <= timeout_nxt;
      core_reset   <= (st_nxt == S_IDLE) || (st_nxt == S_RESET);
      core_enable  <= (st_nxt == S_RUN);
    end
  end

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// tb/tb_riscv_run_ctrl.sv - self-checking bench for riscv_run_ctrl against a behavioural model
module tb_riscv_run_ctrl;

  localparam int A_N = 4, A_RC = 3, A_MAX = 50, A_W = 32;
  localparam int B_N = 1, B_RC = 2, B_MAX = 0,  B_W = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic           a_reset = 1'b0, a_ligar = 1'b0;
  logic [A_N-1:0] a_halt = '0, a_retire = '0;
  logic           a_core_reset, a_core_enable, a_done, a_timeout;
  logic [A_W-1:0] a_cycle_count, a_retire_count;
  logic [2:0]     a_state;

  logic           b_reset = 1'b0, b_ligar = 1'b0;
  logic [B_N-1:0] b_halt = '0, b_retire = '0;
  logic           b_core_reset, b_core_enable, b_done, b_timeout;
  logic [B_W-1:0] b_cycle_count, b_retire_count;
  logic [2:0]     b_state;

  riscv_run_ctrl #(.NUM_CORES(A_N), .RESET_CYCLES(A_RC), .MAX_CYCLES(A_MAX), .CNT_W(A_W)) dut_a (
    .clock(clock), .reset(a_reset), .ligar(a_ligar), .core_halt(a_halt), .core_retire(a_retire),
    .core_reset(a_core_reset), .core_enable(a_core_enable), .cycle_count(a_cycle_count),
    .retire_count(a_retire_count), .state(a_state), .done(a_done), .timeout(a_timeout)
  );

  riscv_run_ctrl #(.NUM_CORES(B_N), .RESET_CYCLES(B_RC), .MAX_CYCLES(B_MAX), .CNT_W(B_W)) dut_b (
    .clock(clock), .reset(b_reset), .ligar(b_ligar), .core_halt(b_halt), .core_retire(b_retire),
    .core_reset(b_core_reset), .core_enable(b_core_enable), .cycle_count(b_cycle_count),
    .retire_count(b_retire_count), .state(b_state), .done(b_done), .timeout(b_timeout)
  );

  // Phase numbers follow the published state encoding; rc = reset cycles still to go.
  typedef struct {
    int     ph;
    int     rc;
    longint cyc;
    longint ret;
    int     mask;
    bit     dn;
    bit     to;
  } mdl_t;

  mdl_t ma = '{0, 0, 0, 0, 0, 1'b0, 1'b0};
  mdl_t mb = '{0, 0, 0, 0, 0, 1'b0, 1'b0};
  int   total = 0, passed = 0;
  bit   chk_en = 1'b0;

  function automatic longint sat(longint v, int w);
    longint top = (longint'(1) << w) - 1;
    return (v > top) ? top : v;
  endfunction

  function automatic mdl_t mstep(mdl_t m, int n, int rcy, longint maxc, int w,
                                 bit rstn, bit lig, int halt, int ret);
    mdl_t r = m;
    if (!rstn) return '{0, 0, 0, 0, 0, 1'b0, 1'b0};
    case (m.ph)
      0: if (lig) r = '{1, rcy, 0, 0, 0, 1'b0, 1'b0};
      1: begin
        r.rc = m.rc - 1;
        if (r.rc == 0) r.ph = 2;
      end
      2: begin
        r.cyc  = sat(m.cyc + 1, w);
        r.ret  = sat(m.ret + $countones(ret), w);
        r.mask = m.mask | halt;
        if (r.mask == (1 << n) - 1) begin
          r.ph = 4; r.dn = 1'b1;
        end else if (maxc != 0 && r.cyc == maxc) begin
          r.ph = 4; r.dn = 1'b1; r.to = 1'b1;
        end else if (!lig) begin
          r.ph = 3;
        end
      end
      3: if (lig) r.ph = 2;
      4: if (!lig) r.ph = 0;
      default: r.ph = 0;
    endcase
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else passed++;
  endtask

  always @(posedge clock) begin
    ma = mstep(ma, A_N, A_RC, A_MAX, A_W, a_reset, a_ligar, int'(a_halt), int'(a_retire));
    mb = mstep(mb, B_N, B_RC, B_MAX, B_W, b_reset, b_ligar, int'(b_halt), int'(b_retire));
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("a_state",   a_state,        ma.ph);
      chk("a_creset",  a_core_reset,   ma.ph <= 1);
      chk("a_enable",  a_core_enable,  ma.ph == 2);
      chk("a_cycles",  a_cycle_count,  ma.cyc);
      chk("a_retired", a_retire_count, ma.ret);
      chk("a_done",    a_done,         ma.dn);
      chk("a_timeout", a_timeout,      ma.to);
      chk("b_state",   b_state,        mb.ph);
      chk("b_creset",  b_core_reset,   mb.ph <= 1);
      chk("b_enable",  b_core_enable,  mb.ph == 2);
      chk("b_cycles",  b_cycle_count,  mb.cyc);
      chk("b_retired", b_retire_count, mb.ret);
      chk("b_done",    b_done,         mb.dn);
      chk("b_timeout", b_timeout,      mb.to);
    end
  end

  initial begin
    int n;
    @(posedge clock);
    @(negedge clock);
    chk_en = 1'b1;
    chk("lit_rst_creset", a_core_reset, 1);
    chk("lit_rst_enable", a_core_enable, 0);
    chk("lit_rst_state", a_state, 0);
    a_reset = 1'b1; b_reset = 1'b1;
    @(negedge clock);

    // Start both; B retires every cycle to drive its 4-bit counters into saturation.
    a_ligar = 1'b1; b_ligar = 1'b1; b_retire = 1'b1;
    @(negedge clock);
    chk("lit_start_state", a_state, 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk("lit_creset_hold", a_core_reset, 1);
    end
    @(negedge clock);
    chk("lit_run_creset", a_core_reset, 0);
    chk("lit_run_enable", a_core_enable, 1);
    chk("lit_run_cycles", a_cycle_count, 0);

    for (int c = 1; c <= 12; c++) begin
      a_retire = 4'hF;
      a_halt = (c == 3) ? 4'h1 : (c == 6) ? 4'h4 : (c == 9) ? 4'h2 : (c == 12) ? 4'h8 : 4'h0;
      @(negedge clock);
      a_halt = 4'h0;
      chk("lit_retire_step", a_retire_count, 4 * c);
      if (c < 12) chk("lit_not_done", a_done, 0);
    end
    chk("lit_halt_done", a_done, 1);
    chk("lit_halt_timeout", a_timeout, 0);
    chk("lit_halt_cycles", a_cycle_count, 12);
    chk("lit_halt_retired", a_retire_count, 48);
    chk("lit_halt_enable", a_core_enable, 0);
    repeat (8) @(negedge clock);
    chk("lit_sat_cycles", b_cycle_count, 15);
    chk("lit_sat_retired", b_retire_count, 15);

    a_ligar = 1'b0; a_retire = '0;
    @(negedge clock);
    chk("lit_idle_state", a_state, 0);
    chk("lit_idle_done_held", a_done, 1);

    a_ligar = 1'b1;
    @(negedge clock);
    n = 0;
    while (a_done !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("lit_to_done", a_done, 1);
    chk("lit_to_timeout", a_timeout, 1);
    chk("lit_to_cycles", a_cycle_count, 50);

    a_ligar = 1'b0;
    @(negedge clock);
    a_ligar = 1'b1;
    repeat (4) @(negedge clock);
    chk("lit_rerun_cycles", a_cycle_count, 0);
    repeat (49) @(negedge clock);
    a_halt = 4'hF;
    @(negedge clock);
    a_halt = 4'h0;
    chk("lit_edge_done", a_done, 1);
    chk("lit_edge_timeout", a_timeout, 0);
    chk("lit_edge_cycles", a_cycle_count, 50);

    a_ligar = 1'b0;
    @(negedge clock);
    a_ligar = 1'b1;
    repeat (4) @(negedge clock);
    a_retire = 4'h1;
    repeat (5) @(negedge clock);
    a_ligar = 1'b0;
    @(negedge clock);
    chk("lit_pause_state", a_state, 3);
    chk("lit_pause_cycles", a_cycle_count, 6);
    repeat (6) @(negedge clock);
    chk("lit_frozen_cycles", a_cycle_count, 6);
    chk("lit_frozen_retired", a_retire_count, 6);
    chk("lit_pause_enable", a_core_enable, 0);
    a_ligar = 1'b1;
    @(negedge clock);
    chk("lit_resume_cycles", a_cycle_count, 6);
    @(negedge clock);
    chk("lit_resume_next", a_cycle_count, 7);
    chk("lit_resume_retired", a_retire_count, 7);

    a_reset = 1'b0;
    @(negedge clock);
    a_reset = 1'b1;
    chk("lit_midrst_state", a_state, 0);
    chk("lit_midrst_cycles", a_cycle_count, 0);
    chk("lit_midrst_creset", a_core_reset, 1);

    repeat (3000) begin
      a_reset  = ($urandom_range(0, 99) != 0);
      a_ligar  = ($urandom_range(0, 9) != 0);
      a_retire = A_N'($urandom);
      for (int i = 0; i < A_N; i++) a_halt[i] = ($urandom_range(0, 19) == 0);
      b_reset  = ($urandom_range(0, 99) != 0);
      b_ligar  = ($urandom_range(0, 7) != 0);
      b_retire = B_N'($urandom);
      b_halt   = B_N'($urandom_range(0, 39) == 0);
      @(negedge clock);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
